// File: rtl/fpga_pb_event_reader_if.sv
// CPU-side read bus for the pushbutton event reader (page-0x80 relative addressing).
interface fpga_pb_event_reader_if;
  logic       read_en;
  logic [7:0] addr;
  logic [7:0] dout;
  logic       key_avail;

  modport master (output read_en, output addr, input dout, input key_avail);
  modport slave  (input read_en, input addr, output dout, output key_avail);
endinterface

// File: rtl/fpga_pb_event_reader.sv
// Pushbutton event reader: sync, debounce, press detect and key-code FIFO popped over the CPU bus.
// Optional macro PB_RELEASE_EVENTS_EN also queues release events (code 8'h80 | index).
module fpga_pb_event_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [20:0]                  pb,
  fpga_pb_event_reader_if.slave        bus
);

  localparam int unsigned NPB = 21;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned DW  = 8;
  localparam logic [7:0]  KEY_ADDR    = 8'd31;
  localparam logic [7:0]  STATUS_ADDR = 8'd32;

  logic [NPB-1:0] sync1, sync2, cand, deb, deb_q;
  logic [CW-1:0]  stab_cnt;
  logic [NPB-1:0] press_pend, press_pend_nx, press_rise, press_clr;
  logic [DW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [4:0]     count;
  logic           ovf, ovf_set;
  logic           empty, full, pop, push, status_rd, can_push;
  logic [DW-1:0]  push_code;
  logic [4:0]     press_idx;
`ifdef PB_RELEASE_EVENTS_EN
  logic [NPB-1:0] rel_pend, rel_pend_nx, rel_fall, rel_clr;
  logic [4:0]     rel_idx;
`endif

  function automatic logic [4:0] lowest_idx(input logic [NPB-1:0] v);
    lowest_idx = '0;
    for (int i = NPB - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 5'(i);
    end
  endfunction

  // Two-flop synchroniser, then a candidate that must hold for DEBOUNCE_CYCLES before acceptance
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      deb      <= '0;
      deb_q    <= '0;
      stab_cnt <= '0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 != cand) begin
        cand     <= sync2;
        stab_cnt <= '0;
      end else if (stab_cnt != CW'(DEBOUNCE_CYCLES - 1)) begin
        stab_cnt <= stab_cnt + CW'(1);
      end else begin
        deb <= cand;
      end
    end
  end

  assign empty      = (count == 5'd0);
  assign full       = (count == 5'(FIFO_DEPTH));
  assign pop        = bus.read_en && (bus.addr == KEY_ADDR) && !empty;
  assign status_rd  = bus.read_en && (bus.addr == STATUS_ADDR);
  assign can_push   = !full || pop;
  assign press_rise = deb & ~deb_q;
  assign press_idx  = lowest_idx(press_pend);
`ifdef PB_RELEASE_EVENTS_EN
  assign rel_fall   = ~deb & deb_q;
  assign rel_idx    = lowest_idx(rel_pend);
`endif

  // Arbitration: presses before releases, lowest index first; a full FIFO holds pending bits
  always_comb begin
    push      = 1'b0;
    push_code = '0;
    press_clr = '0;
`ifdef PB_RELEASE_EVENTS_EN
    rel_clr   = '0;
`endif
    if (can_push && (press_pend != '0)) begin
      push                 = 1'b1;
      push_code            = {3'b000, press_idx};
      press_clr[press_idx] = 1'b1;
    end
`ifdef PB_RELEASE_EVENTS_EN
    else if (can_push && (rel_pend != '0)) begin
      push             = 1'b1;
      push_code        = {3'b100, rel_idx};
      rel_clr[rel_idx] = 1'b1;
    end
`endif
    press_pend_nx = (press_pend & ~press_clr) | press_rise;
    ovf_set       = |(press_rise & press_pend & ~press_clr);
`ifdef PB_RELEASE_EVENTS_EN
    rel_pend_nx   = (rel_pend & ~rel_clr) | rel_fall;
    ovf_set       = ovf_set | (|(rel_fall & rel_pend & ~rel_clr));
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      press_pend <= '0;
`ifdef PB_RELEASE_EVENTS_EN
      rel_pend   <= '0;
`endif
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      press_pend <= press_pend_nx;
`ifdef PB_RELEASE_EVENTS_EN
      rel_pend   <= rel_pend_nx;
`endif
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
      // A fresh overflow in the same cycle as a STATUS read keeps the flag set
      if (ovf_set)        ovf <= 1'b1;
      else if (status_rd) ovf <= 1'b0;
    end
  end

  // Storage needs no reset: only entries between rptr and wptr are ever observed
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_code;
  end

  always_comb begin
    bus.dout = 8'h00;
    if (bus.read_en) begin
      case (bus.addr)
        KEY_ADDR:    bus.dout = empty ? 8'hFF : mem[rptr];
        STATUS_ADDR: bus.dout = {ovf, 2'b00, count};
        default:     bus.dout = 8'h00;
      endcase
    end
  end

  assign bus.key_avail = !empty;

endmodule

// File: tb/tb_fpga_pb_event_reader.sv
// Self-checking bench for fpga_pb_event_reader: vector table plus scoreboard of expected key codes.
module tb_fpga_pb_event_reader;

  localparam int unsigned D     = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SETTLE = 2 * D + 10;
  localparam logic [7:0]  KEY  = 8'd31;
  localparam logic [7:0]  STAT = 8'd32;

  logic        clk;
  logic        nrst;
  logic [20:0] pb;

  fpga_pb_event_reader_if bus ();

  fpga_pb_event_reader #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .pb   (pb),
    .bus  (bus)
  );

  int         n_vec;
  int         n_err;
  logic [7:0] sb [$];

  typedef struct {
    logic [20:0] mask;
    int unsigned hold;
    bit          fires;
  } vec_t;

  vec_t vecs [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the following posedge
  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    bus.read_en = 1'b1;
    bus.addr    = a;
    @(negedge clk);
    d = bus.dout;
    @(posedge clk);
    #1;
    bus.read_en = 1'b0;
    bus.addr    = 8'h00;
  endtask

  task automatic key_read(input string name);
    logic [7:0] d, e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'hFF;
    bus_read(KEY, d);
    check(name, d, e);
  endtask

  task automatic status_read(input string name, input logic exp_ovf);
    logic [7:0] d;
    bus_read(STAT, d);
    check(name, d, {exp_ovf, 2'b00, 5'(sb.size())});
  endtask

  task automatic avail_check(input string name);
    logic e;
    e = (sb.size() != 0);
    @(negedge clk);
    check(name, {7'b0, bus.key_avail}, {7'b0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [20:0] mask, input int unsigned hold);
    pb = mask;
    tick(hold);
    pb = '0;
  endtask

  initial begin
    logic [7:0] d;
    bit         found;
    int         n;

    n_vec = 0;
    n_err = 0;
    nrst        = 1'b0;
    pb          = '0;
    bus.read_en = 1'b0;
    bus.addr    = 8'h00;

    vecs[0] = '{mask: 21'h000020, hold: D + 4, fires: 1'b1};
    vecs[1] = '{mask: 21'h000008, hold: D - 3, fires: 1'b0};
    vecs[2] = '{mask: 21'h000084, hold: D + 4, fires: 1'b1};
    vecs[3] = '{mask: 21'h100000, hold: D + 4, fires: 1'b1};
    vecs[4] = '{mask: 21'h080003, hold: 40,    fires: 1'b1};
    vecs[5] = '{mask: 21'h000400, hold: 1,     fires: 1'b0};

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_avail", {7'b0, bus.key_avail}, 8'h00);
    check("rst_dout", bus.dout, 8'h00);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    tick(2);
    bus.addr = KEY;
    @(negedge clk);
    check("idle_dout", bus.dout, 8'h00);
    @(posedge clk);
    #1;
    status_read("rst_status", 1'b0);
    key_read("rst_key_empty");
    bus_read(8'd5, d);
    check("other_addr", d, 8'h00);

    // Table-driven press patterns
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].mask, vecs[i].hold);
      if (vecs[i].fires) begin
        for (int b = 0; b < 21; b++)
          if (vecs[i].mask[b]) sb.push_back({3'b000, 5'(b)});
`ifdef PB_RELEASE_EVENTS_EN
        for (int b = 0; b < 21; b++)
          if (vecs[i].mask[b]) sb.push_back({3'b100, 5'(b)});
`endif
      end
      tick(SETTLE);
      status_read($sformatf("v%0d_status", i), 1'b0);
      avail_check($sformatf("v%0d_avail", i));
      n = sb.size();
      for (int k = 0; k < n; k++) key_read($sformatf("v%0d_key%0d", i, k));
      key_read($sformatf("v%0d_key_empty", i));
      avail_check($sformatf("v%0d_avail_after", i));
    end

`ifndef PB_RELEASE_EVENTS_EN
    // Fill the FIFO, then press pb[0] twice while full
    press(21'h00FF00, D + 4);
    for (int b = 8; b < 16; b++) sb.push_back({3'b000, 5'(b)});
    tick(SETTLE);
    status_read("fill_status", 1'b0);
    press(21'h000001, D + 4);
    tick(SETTLE);
    press(21'h000001, D + 4);
    tick(SETTLE);
    status_read("ovf_status", 1'b1);
    status_read("ovf_cleared", 1'b0);
    key_read("ovf_pop");
    sb.push_back(8'h00);
    status_read("ovf_refill_status", 1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) key_read($sformatf("ovf_drain%0d", k));
    key_read("ovf_drain_empty");
    status_read("ovf_final_status", 1'b0);

    // Back-to-back pops while pushes continue, crossing pointer wrap
    press(21'h000006, D + 4);
    sb.push_back(8'h01);
    sb.push_back(8'h02);
    tick(SETTLE);
    pb = 21'h1F0000;
    for (int b = 16; b < 21; b++) sb.push_back({3'b000, 5'(b)});
    found = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      bus_read(STAT, d);
      if (d[4:0] == 5'd3) found = 1'b1;
    end
    check("wrap_poll", {7'b0, found}, 8'h01);
    bus.read_en = 1'b1;
    bus.addr    = KEY;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("wrap_pop%0d", k), bus.dout, sb.pop_front());
      check($sformatf("wrap_pop_avail%0d", k), {7'b0, bus.key_avail}, 8'h01);
      @(posedge clk);
      #1;
    end
    bus.read_en = 1'b0;
    bus.addr    = 8'h00;
    pb = '0;
    tick(SETTLE);
    status_read("wrap_status", 1'b0);
    n = sb.size();
    for (int k = 0; k < n; k++) key_read($sformatf("wrap_drain%0d", k));
    key_read("wrap_drain_empty");

    // Reset pulse mid-debounce with four entries queued
    press(21'h0000F0, D + 4);
    for (int b = 4; b < 8; b++) sb.push_back({3'b000, 5'(b)});
    tick(SETTLE);
    status_read("pre_rst_status", 1'b0);
    pb = 21'h000200;
    tick(8);
    @(negedge clk);
    nrst = 1'b0;
    bus.read_en = 1'b1;
    bus.addr    = STAT;
    #1;
    check("midrst_status", bus.dout, 8'h00);
    check("midrst_avail", {7'b0, bus.key_avail}, 8'h00);
    bus.read_en = 1'b0;
    bus.addr    = 8'h00;
    sb.delete();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    sb.push_back(8'h09);
    tick(SETTLE);
    pb = '0;
    tick(SETTLE);
    status_read("post_rst_status", 1'b0);
    key_read("post_rst_key");
    key_read("post_rst_empty");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
